// File: rtl/otbn_urnd_reseed_responder.sv
// URND reseed responder: fetches SeedWords EDN words on request, loads them into a
// Galois LFSR and exposes the LFSR state as URND data, stepping it on advance.
module otbn_urnd_reseed_responder #(
  parameter int unsigned          EdnDataWidth = 32,
  parameter int unsigned          SeedWords    = 2,
  parameter int unsigned          UrndWidth    = 64,
  parameter logic [UrndWidth-1:0] LfsrTaps     = 64'hD800_0000_0000_0000,
  parameter logic [UrndWidth-1:0] DefaultSeed  = 64'h5A5A_C3C3_0F0F_9696
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    urnd_reseed_req_i,
  output logic                    urnd_reseed_busy_o,
  input  logic                    urnd_advance_i,
  output logic [UrndWidth-1:0]    urnd_data_o,
  output logic                    edn_req_o,
  input  logic                    edn_ack_i,
  input  logic [EdnDataWidth-1:0] edn_data_i
);

  localparam int unsigned CntW = (SeedWords > 1) ? $clog2(SeedWords) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StCommit
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [CntW-1:0]       r_word_cnt;
  logic [UrndWidth-1:0]  r_seed;
  logic [UrndWidth-1:0]  r_lfsr;
  logic                  w_last_word;
  logic [UrndWidth-1:0]  w_lfsr_step;
  logic [UrndWidth-1:0]  w_commit_seed;

  assign w_last_word   = (r_word_cnt == CntW'(SeedWords - 1));
  assign w_lfsr_step   = (r_lfsr >> 1) ^ (r_lfsr[0] ? LfsrTaps : '0);
  // An all-zero seed would lock the LFSR, so fall back to the default seed.
  assign w_commit_seed = (r_seed == '0) ? DefaultSeed : r_seed;

  // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (urnd_reseed_req_i)            w_state_next = StFetch;
      StFetch:  if (edn_ack_i && w_last_word)     w_state_next = StCommit;
      StCommit:                                   w_state_next = StIdle;
      default:                                    w_state_next = StIdle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the seed buffer is reset too, so a fetch abandoned by reset leaves no stale entropy behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_word_cnt <= '0;
      r_seed     <= '0;
    end else if (r_state == StIdle && urnd_reseed_req_i) begin
      r_word_cnt <= '0;
    end else if (r_state == StFetch && edn_ack_i) begin
      for (int unsigned w = 0; w < SeedWords; w++) begin
        if (r_word_cnt == CntW'(w)) begin
          r_seed[w*EdnDataWidth +: EdnDataWidth] <= edn_data_i;
        end
      end
      if (!w_last_word) begin
        r_word_cnt <= r_word_cnt + CntW'(1);
      end
    end
  end

  // Commit load wins; advance is only honoured while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= DefaultSeed;
    end else if (r_state == StCommit) begin
      r_lfsr <= w_commit_seed;
    end else if (r_state == StIdle && urnd_advance_i) begin
      r_lfsr <= w_lfsr_step;
    end
  end

  assign urnd_reseed_busy_o = (r_state != StIdle);
  assign edn_req_o          = (r_state == StFetch);
  assign urnd_data_o        = r_lfsr;

  a_state_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_state inside {StIdle, StFetch, StCommit});
  a_lfsr_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_lfsr != '0);
  a_edn_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (edn_req_o && !edn_ack_i) |=> edn_req_o);
  a_reseed_req_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    urnd_reseed_req_i |-> (r_state == StIdle));
  a_edn_ack_fetch: assert property (@(posedge clk_i) disable iff (!rst_ni)
    edn_ack_i |-> (r_state == StFetch));
  a_known_outputs: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown({urnd_reseed_busy_o, edn_req_o, urnd_data_o}));

endmodule

// File: tb/tb_otbn_urnd_reseed_responder.sv
// Self-checking bench for otbn_urnd_reseed_responder: random reseeds and advances
// checked against a transaction-level model of the URND value and handshake.
module tb_otbn_urnd_reseed_responder;

  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DEF  = 64'h5A5A_C3C3_0F0F_9696;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        urnd_reseed_req_i;
  logic        urnd_reseed_busy_o;
  logic        urnd_advance_i;
  logic [63:0] urnd_data_o;
  logic        edn_req_o;
  logic        edn_ack_i;
  logic [31:0] edn_data_i;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [63:0] model;

  otbn_urnd_reseed_responder dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .urnd_reseed_req_i  (urnd_reseed_req_i),
    .urnd_reseed_busy_o (urnd_reseed_busy_o),
    .urnd_advance_i     (urnd_advance_i),
    .urnd_data_o        (urnd_data_o),
    .edn_req_o          (edn_req_o),
    .edn_ack_i          (edn_ack_i),
    .edn_data_i         (edn_data_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] lfsr_step(input logic [63:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : 64'h0);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_advance(input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      check("idle_busy", 64'(urnd_reseed_busy_o), 64'h0);
      check("idle_data", urnd_data_o, model);
      urnd_advance_i = ($urandom_range(99) < pct);
      tick();
      if (urnd_advance_i) model = lfsr_step(model);
      urnd_advance_i = 1'b0;
    end
  endtask

  // One full reseed transaction: request, SeedWords acked words with stalls, commit.
  task automatic reseed(input logic [31:0] w0, input logic [31:0] w1,
                        input int st0, input int st1, input bit noise);
    logic [31:0] words[2];
    int          stall[2];
    logic [63:0] seed;
    words[0] = w0; words[1] = w1;
    stall[0] = st0; stall[1] = st1;
    check("req_idle_busy", 64'(urnd_reseed_busy_o), 64'h0);
    urnd_reseed_req_i = 1'b1;
    urnd_advance_i    = noise ? 1'($urandom_range(1)) : 1'b0;
    tick();
    if (urnd_advance_i) model = lfsr_step(model);
    urnd_reseed_req_i = 1'b0;
    for (int w = 0; w < 2; w++) begin
      for (int s = 0; s <= stall[w]; s++) begin
        check("fetch_busy", 64'(urnd_reseed_busy_o), 64'h1);
        check("fetch_edn_req", 64'(edn_req_o), 64'h1);
        check("fetch_data_hold", urnd_data_o, model);
        urnd_advance_i = noise ? 1'($urandom_range(1)) : 1'b0;
        edn_ack_i      = (s == stall[w]);
        edn_data_i     = edn_ack_i ? words[w] : $urandom;
        tick();
        edn_ack_i = 1'b0;
      end
    end
    check("commit_busy", 64'(urnd_reseed_busy_o), 64'h1);
    check("commit_edn_req", 64'(edn_req_o), 64'h0);
    check("commit_data_hold", urnd_data_o, model);
    urnd_advance_i = noise ? 1'($urandom_range(1)) : 1'b0;
    tick();
    urnd_advance_i = 1'b0;
    seed  = {words[1], words[0]};
    model = (seed == 64'h0) ? DEF : seed;
    check("done_busy", 64'(urnd_reseed_busy_o), 64'h0);
    check("done_edn_req", 64'(edn_req_o), 64'h0);
    check("done_data", urnd_data_o, model);
  endtask

  initial begin
    rst_ni            = 1'b0;
    urnd_reseed_req_i = 1'b0;
    urnd_advance_i    = 1'b0;
    edn_ack_i         = 1'b0;
    edn_data_i        = '0;
    model             = DEF;

    // Reset values, during and after reset with no stimulus.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_data", urnd_data_o, 64'h5A5AC3C30F0F9696);
    check("rst_busy", 64'(urnd_reseed_busy_o), 64'h0);
    check("rst_edn_req", 64'(edn_req_o), 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    run_advance(2, 0);

    // Back-to-back acks, known seed, then one plain-shift advance.
    reseed(32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 1'b0);
    check("t2_const", urnd_data_o, 64'h9ABCDEF0_12345678);
    urnd_advance_i = 1'b1;
    tick();
    urnd_advance_i = 1'b0;
    model = lfsr_step(model);
    check("t3_shift", urnd_data_o, 64'h4D5E6F78_091A2B3C);

    // Seed of 1 wraps into the feedback taps.
    reseed(32'h1, 32'h0, 0, 0, 1'b0);
    urnd_advance_i = 1'b1;
    tick();
    urnd_advance_i = 1'b0;
    model = lfsr_step(model);
    check("t3_taps", urnd_data_o, 64'hD800_0000_0000_0000);

    // All-zero seed substitutes the default and keeps running.
    reseed(32'h0, 32'h0, 0, 0, 1'b0);
    check("t4_zero_seed", urnd_data_o, DEF);
    run_advance(6, 100);

    // Five-cycle ack stalls with advance noise during fetch.
    reseed($urandom, $urandom, 5, 5, 1'b1);

    // Reset after the first ack abandons the fetch.
    urnd_reseed_req_i = 1'b1;
    tick();
    urnd_reseed_req_i = 1'b0;
    edn_ack_i  = 1'b1;
    edn_data_i = 32'hDEAD_BEEF;
    tick();
    edn_ack_i = 1'b0;
    check("t6_pre_edn_req", 64'(edn_req_o), 64'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    model = DEF;
    check("t6_rst_busy", 64'(urnd_reseed_busy_o), 64'h0);
    check("t6_rst_edn_req", 64'(edn_req_o), 64'h0);
    check("t6_rst_data", urnd_data_o, DEF);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    reseed(32'hCAFE_F00D, 32'h0BAD_1DEA, 1, 0, 1'b0);

    // Randomized reseeds and advance bursts.
    for (int it = 0; it < 25; it++) begin
      logic [31:0] a, b;
      a = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
      b = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
      reseed(a, b, $urandom_range(4), $urandom_range(4), 1'b1);
      run_advance($urandom_range(1, 12), 60);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
